// File: rtl/multicycle_control.sv
// Moore sequencing controller for the multicycle MIPS datapath.
// Optional memory wait-state handshake is enabled by defining MC_MEM_HANDSHAKE_EN.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUControl,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_t      state_r;
   state_t      state_next_s;
   logic        mem_ready_s;
   logic        iord_s;
   logic        mem_write_s;
   logic        ir_write_s;
   logic        reg_dst_s;
   logic        mem_to_reg_s;
   logic        reg_write_s;
   logic        alu_src_a_s;
   logic [1:0]  alu_src_b_s;
   logic [3:0]  alu_control_s;
   logic [1:0]  pc_src_s;
   logic        pc_write_s;
   logic        branch_s;

   function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
      logic [3:0] alu;
      case (funct)
         6'b100000: alu = ALU_ADD;
         6'b100010: alu = ALU_SUB;
         6'b100100: alu = ALU_AND;
         6'b100101: alu = ALU_OR;
         6'b101010: alu = ALU_SLT;
         default:   alu = ALU_AND;
      endcase
      return alu;
   endfunction

`ifdef MC_MEM_HANDSHAKE_EN
   assign mem_ready_s = MemReady;
`else
   // Without the handshake every memory access completes in one cycle.
   logic unused_mem_ready_s;
   assign unused_mem_ready_s = MemReady;
   assign mem_ready_s        = 1'b1;
`endif

   // State register with synchronous reset to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and raw Moore control decode.
   always_comb begin
      state_next_s  = S_FETCH;
      iord_s        = 1'b0;
      mem_write_s   = 1'b0;
      ir_write_s    = 1'b0;
      reg_dst_s     = 1'b0;
      mem_to_reg_s  = 1'b0;
      reg_write_s   = 1'b0;
      alu_src_a_s   = 1'b0;
      alu_src_b_s   = 2'b00;
      alu_control_s = 4'b0000;
      pc_src_s      = 2'b00;
      pc_write_s    = 1'b0;
      branch_s      = 1'b0;
      case (state_r)
         S_FETCH: begin
            alu_src_b_s   = 2'b01;
            alu_control_s = ALU_ADD;
            // IR/PC load only on the completing cycle so the PC advances once.
            ir_write_s    = mem_ready_s;
            pc_write_s    = mem_ready_s;
            if (mem_ready_s) begin
               state_next_s = S_DECODE;
            end else begin
               state_next_s = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b_s   = 2'b11;
            alu_control_s = ALU_ADD;
            case (Op)
               OP_LW:    state_next_s = S_MEMADR;
               OP_SW:    state_next_s = S_MEMADR;
               OP_RTYPE: state_next_s = S_EXEC;
               OP_BEQ:   state_next_s = S_BRANCH;
               OP_ADDI:  state_next_s = S_ADDIEX;
               OP_J:     state_next_s = S_JUMP;
               default:  state_next_s = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s   = 1'b1;
            alu_src_b_s   = 2'b10;
            alu_control_s = ALU_ADD;
            if (Op == OP_LW) begin
               state_next_s = S_MEMRD;
            end else begin
               state_next_s = S_MEMWR;
            end
         end
         S_MEMRD: begin
            iord_s = 1'b1;
            if (mem_ready_s) begin
               state_next_s = S_MEMWB;
            end else begin
               state_next_s = S_MEMRD;
            end
         end
         S_MEMWB: begin
            mem_to_reg_s = 1'b1;
            reg_write_s  = 1'b1;
            state_next_s = S_FETCH;
         end
         S_MEMWR: begin
            iord_s      = 1'b1;
            mem_write_s = 1'b1;
            if (mem_ready_s) begin
               state_next_s = S_FETCH;
            end else begin
               state_next_s = S_MEMWR;
            end
         end
         S_EXEC: begin
            alu_src_a_s   = 1'b1;
            alu_src_b_s   = 2'b00;
            alu_control_s = funct_to_alu(Funct);
            state_next_s  = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst_s    = 1'b1;
            reg_write_s  = 1'b1;
            state_next_s = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_s   = 1'b1;
            alu_src_b_s   = 2'b00;
            alu_control_s = ALU_SUB;
            pc_src_s      = 2'b01;
            branch_s      = 1'b1;
            state_next_s  = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a_s   = 1'b1;
            alu_src_b_s   = 2'b10;
            alu_control_s = ALU_ADD;
            state_next_s  = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_s  = 1'b1;
            state_next_s = S_FETCH;
         end
         S_JUMP: begin
            pc_src_s     = 2'b10;
            pc_write_s   = 1'b1;
            state_next_s = S_FETCH;
         end
         default: begin
            state_next_s = S_FETCH;
         end
      endcase
   end

   // Port drive; reset silences every strobe and select but not the state view.
   always_comb begin
      State = state_r;
      if (reset) begin
         IorD       = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegDst     = 1'b0;
         MemtoReg   = 1'b0;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'b00;
         ALUControl = 4'b0000;
         PCSrc      = 2'b00;
         PCEn       = 1'b0;
      end else begin
         IorD       = iord_s;
         MemWrite   = mem_write_s;
         IRWrite    = ir_write_s;
         RegDst     = reg_dst_s;
         MemtoReg   = mem_to_reg_s;
         RegWrite   = reg_write_s;
         ALUSrcA    = alu_src_a_s;
         ALUSrcB    = alu_src_b_s;
         ALUControl = alu_control_s;
         PCSrc      = pc_src_s;
         PCEn       = pc_write_s | (branch_s & Zero);
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; expected words are hand-built per state.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       MemReady;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
   logic [1:0] ALUSrcB, PCSrc;
   logic [3:0] ALUControl, State;
   logic [19:0] obs_s;

   int vectors_r    = 0;
   int miscompares_r = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .State(State)
   );

   always #5 clk = ~clk;

   assign obs_s = {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn};

   // Expected word: state, then controls in the same order as obs_s.
   function automatic logic [19:0] ew(input logic [3:0] st, input logic iord, input logic mw,
                                      input logic irw, input logic rd, input logic m2r,
                                      input logic rw, input logic asa, input logic [1:0] asb,
                                      input logic [3:0] aluc, input logic [1:0] pcs,
                                      input logic pcen);
      return {st, iord, mw, irw, rd, m2r, rw, asa, asb, aluc, pcs, pcen};
   endfunction

   task automatic check_value(input string tag, input logic [19:0] actual,
                              input logic [19:0] expected);
      vectors_r++;
      if (actual !== expected) begin
         miscompares_r++;
         $display("FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
      end
   endtask

   task automatic step_check(input string tag, input logic [19:0] expected);
      @(posedge clk);
      #1;
      check_value(tag, obs_s, expected);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
      logic [19:0] e_aluwb, e_addiex, e_addiwb, e_jump, e_fetch_wait;
      logic [5:0]  functs [6];
      logic [3:0]  alucs  [6];

      e_fetch      = ew(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0010, 2'b00, 1'b1);
      e_fetch_wait = ew(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0010, 2'b00, 1'b0);
      e_decode     = ew(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0010, 2'b00, 1'b0);
      e_memadr     = ew(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0010, 2'b00, 1'b0);
      e_memrd      = ew(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0);
      e_memwb      = ew(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0);
      e_memwr      = ew(4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0);
      e_aluwb      = ew(4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0);
      e_addiex     = ew(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0010, 2'b00, 1'b0);
      e_addiwb     = ew(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0);
      e_jump       = ew(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b10, 1'b1);

      functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
      alucs  = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b0000};

      reset = 1'b1;
      Op    = 6'b000000;
      Funct = 6'b000000;
      Zero  = 1'b0;
`ifdef MC_MEM_HANDSHAKE_EN
      MemReady = 1'b1;
`else
      MemReady = 1'b0;
`endif

      // Reset held three cycles: state FETCH, every output low.
      for (int i = 0; i < 3; i++) begin
         step_check("reset_hold", 20'h00000);
      end
      reset = 1'b0;
      #1;
      check_value("first_fetch", obs_s, e_fetch);

      // LW: five cycles.
      Op = 6'b100011;
      step_check("lw_decode", e_decode);
      step_check("lw_memadr", e_memadr);
      step_check("lw_memrd", e_memrd);
      step_check("lw_memwb", e_memwb);
      step_check("lw_fetch", e_fetch);

      // SW: four cycles.
      Op = 6'b101011;
      step_check("sw_decode", e_decode);
      step_check("sw_memadr", e_memadr);
      step_check("sw_memwr", e_memwr);
      step_check("sw_fetch", e_fetch);

      // R-type over every listed Funct plus an unknown one.
      Op = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         Funct = functs[i];
         step_check("r_decode", e_decode);
         step_check("r_exec", ew(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                                 alucs[i], 2'b00, 1'b0));
         step_check("r_aluwb", e_aluwb);
         step_check("r_fetch", e_fetch);
      end

      // BEQ: PCEn follows Zero combinationally inside BRANCH.
      Op   = 6'b000100;
      Zero = 1'b1;
      step_check("beq_decode", e_decode);
      step_check("beq_taken", ew(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                                 4'b0110, 2'b01, 1'b1));
      Zero = 1'b0;
      #1;
      check_value("beq_not_taken", obs_s, ew(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                             2'b00, 4'b0110, 2'b01, 1'b0));
      step_check("beq_fetch", e_fetch);

      // ADDI: four cycles.
      Op = 6'b001000;
      step_check("addi_decode", e_decode);
      step_check("addi_ex", e_addiex);
      step_check("addi_wb", e_addiwb);
      step_check("addi_fetch", e_fetch);

      // J: three cycles.
      Op = 6'b000010;
      step_check("j_decode", e_decode);
      step_check("j_jump", e_jump);
      step_check("j_fetch", e_fetch);

      // Unknown opcode behaves as a two-cycle NOP.
      Op = 6'b111111;
      step_check("nop_decode", e_decode);
      step_check("nop_fetch", e_fetch);

      // Reset in MEMRD abandons the load before MEMWB.
      Op = 6'b100011;
      step_check("abort_decode", e_decode);
      step_check("abort_memadr", e_memadr);
      step_check("abort_memrd", e_memrd);
      reset = 1'b1;
      #1;
      check_value("abort_reset_in_memrd", obs_s, {4'd3, 16'h0000});
      step_check("abort_reset_fetch", 20'h00000);
      reset = 1'b0;
      #1;
      check_value("abort_release", obs_s, e_fetch);
      step_check("abort_next_decode", e_decode);
      step_check("abort_next_memadr", e_memadr);
      step_check("abort_next_memrd", e_memrd);
      step_check("abort_next_memwb", e_memwb);
      step_check("abort_next_fetch", e_fetch);

`ifdef MC_MEM_HANDSHAKE_EN
      // FETCH wait: no IR/PC load until MemReady.
      MemReady = 1'b0;
      #1;
      check_value("hs_fetch_wait0", obs_s, e_fetch_wait);
      step_check("hs_fetch_wait1", e_fetch_wait);
      MemReady = 1'b1;
      #1;
      check_value("hs_fetch_ready", obs_s, e_fetch);
      // SW with two wait cycles in MEMWR.
      Op = 6'b101011;
      step_check("hs_sw_decode", e_decode);
      step_check("hs_sw_memadr", e_memadr);
      MemReady = 1'b0;
      step_check("hs_sw_memwr0", e_memwr);
      step_check("hs_sw_memwr1", e_memwr);
      step_check("hs_sw_memwr2", e_memwr);
      MemReady = 1'b1;
      step_check("hs_sw_fetch", e_fetch);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors_r, miscompares_r);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle MIPS datapath. It replaces single-cycle decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. This lets one ALU and one unified memory be shared across phases. It drives every datapath mux select and write enable, and combines the branch condition into a single PC enable.

## Interface
Parameters:
- none; opcode/funct and ALUControl encodings are fixed: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Op  in  6  opcode from instruction register
- Funct  in  6  function field from instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory access complete; used only with MC_MEM_HANDSHAKE_EN
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 1 = rd, 0 = rt
- MemtoReg  out  1  write-back data select: 1 = memory data, 0 = ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  4  ALU operation
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load, equal to PCWrite | (Branch & Zero)
- State  out  4  current state, for debug

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- codes 12–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH→DECODE.
- DECODE dispatches on Op:
  - LW (100011) or SW (101011) → MEMADR
  - R-type (000000) → EXEC
  - BEQ (000100) → BRANCH
  - ADDI (001000) → ADDIEX
  - J (000010) → JUMP
  - any other opcode → FETCH, i.e. treated as a NOP.
- MEMADR→MEMRD if Op = LW, else → MEMWR.
- MEMRD→MEMWB.
- EXEC→ALUWB.
- ADDIEX→ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP → FETCH.

Outputs are Moore. Any output not listed for a state is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=0010, PCSrc=00, IRWrite=1, PCWrite=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=0010 (precomputes branch target).
- MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=0010.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct:
  - 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111
  - any other Funct → 0000.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=0110, PCSrc=01, Branch=1 (internal).
- JUMP: PCSrc=10, PCWrite=1.

## Timing
- Reset is synchronous. An edge with reset=1 loads FETCH.
- While reset=1, all outputs are forced to 0, combinationally from reset. This includes PCEn, IRWrite, MemWrite and RegWrite. State is excluded: it shows the registered value.
- The first active FETCH cycle is the first cycle after reset deasserts.
- Reset mid-instruction abandons the instruction; no further write strobes are issued.
- Cycles per instruction, no stalls:
  - LW 5
  - SW, R-type, ADDI 4
  - BEQ, J 3
  - unknown opcode 2
- Op is sampled only in DECODE and MEMADR. Funct is sampled only in EXEC. Both are assumed stable from IR load until FETCH.
- PCEn is combinational from State and Zero. In BRANCH it follows Zero within the same cycle.

## Configuration
- MC_MEM_HANDSHAKE_EN defined:
  - FETCH, MEMRD and MEMWR hold their state while MemReady=0.
  - MemWrite and IorD stay asserted through the whole wait.
  - IRWrite and PCWrite (hence PCEn) assert in FETCH only in cycles where MemReady=1, so the PC advances exactly once.
  - The state advances on the edge where MemReady=1.
- MC_MEM_HANDSHAKE_EN undefined:
  - MemReady is ignored.
  - Each of those states lasts exactly one cycle.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; State=0 with IRWrite=1, PCEn=1, ALUSrcB=01 on the first cycle after release.
- Op=100011 (LW) → State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; 5 cycles per instruction.
- Op=000000, Funct=101010 → ALUControl=0111 in EXEC; state 7 has RegDst=1, RegWrite=1; Funct=111111 → ALUControl=0000.
- Op=000100 with Zero=1 → PCEn=1, PCSrc=01 in state 8; with Zero=0 → PCEn=0; back to FETCH after 3 cycles.
- Op=111111 → DECODE→FETCH with no write strobe asserted; reset asserted in state 3 → FETCH next edge with RegWrite never asserted.
- With MC_MEM_HANDSHAKE_EN, SW with MemReady low for 2 cycles in MEMWR → MemWrite=1 for 3 cycles, then FETCH; MemReady low in FETCH → PCEn asserts exactly once.
